// File: rtl/fpnew_opgroup_arbiter_pkg.sv
// Shared types for the opgroup arbiter slice: fpnew rounding/operation/status
// encodings and the requester-ID width helper.
package fpnew_opgroup_arbiter_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL,
        DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I,
        I2F, CPKAB, CPKCD
    } operation_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    // Width of an index into n items, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpnew_id_fifo.sv
// Requester-ID FIFO tracking in-flight operations of an in-order slice.
// Pointers wrap by explicit compare so any depth is legal.
module fpnew_id_fifo
    import fpnew_opgroup_arbiter_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [IdWidth-1:0] id_i,
    input  logic               pop_i,
    output logic [IdWidth-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned PtrWidth = clog2_min1(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [IdWidth-1:0]  mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                push_en, pop_en;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Full is judged on the registered count: a same-cycle pop never frees a slot.
    assign push_en = push_i & ~full_o & ~flush_i;
    assign pop_en  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= id_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_en) rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push_en && !pop_en)      count_q <= count_q + CntWidth'(1);
            else if (pop_en && !push_en) count_q <= count_q - CntWidth'(1);
        end
    end

endmodule

// File: rtl/fpnew_opgroup_arbiter.sv
// Round-robin sharing of one in-order opgroup slice between NumReq requesters;
// results are steered back by the requester ID held at the ID FIFO head.
module fpnew_opgroup_arbiter
    import fpnew_opgroup_arbiter_pkg::*;
#(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned Width       = 32,
    parameter int unsigned NumOperands = 3,
    parameter int unsigned MaxInflight = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          flush_i,
    input  logic [NumReq-1:0]                             req_valid_i,
    output logic [NumReq-1:0]                             req_ready_o,
    input  logic [NumReq-1:0][NumOperands-1:0][Width-1:0] req_operands_i,
    input  logic [NumReq-1:0][NumOperands-1:0]            req_is_boxed_i,
    input  roundmode_e [NumReq-1:0]                       req_rnd_mode_i,
    input  operation_e [NumReq-1:0]                       req_op_i,
    input  logic [NumReq-1:0]                             req_op_mod_i,
    input  logic [NumReq-1:0]                             req_vectorial_i,
    output logic                                          slv_valid_o,
    input  logic                                          slv_ready_i,
    output logic [NumOperands-1:0][Width-1:0]             slv_operands_o,
    output logic [NumOperands-1:0]                        slv_is_boxed_o,
    output roundmode_e                                    slv_rnd_mode_o,
    output operation_e                                    slv_op_o,
    output logic                                          slv_op_mod_o,
    output logic                                          slv_vectorial_o,
    output logic                                          slv_flush_o,
    input  logic                                          slv_out_valid_i,
    output logic                                          slv_out_ready_o,
    input  logic [Width-1:0]                              slv_result_i,
    input  status_t                                       slv_status_i,
    output logic [NumReq-1:0]                             rsp_valid_o,
    input  logic [NumReq-1:0]                             rsp_ready_i,
    output logic [Width-1:0]                              rsp_result_o,
    output status_t                                       rsp_status_o,
    output logic                                          busy_o
);

    localparam int unsigned IdWidth = clog2_min1(NumReq);

    logic [IdWidth-1:0] rr_q, lock_idx_q, arb_idx, grant, fifo_head;
    logic               lock_q, found, can_issue, accept, pop, rsp_active;
    logic               fifo_full, fifo_empty;
    int unsigned        cand;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        arb_idx = rr_q;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = (32'(rr_q) + i) % NumReq;
            if (!found && req_valid_i[IdWidth'(cand)]) begin
                arb_idx = IdWidth'(cand);
                found   = 1'b1;
            end
        end
    end

    // A stalled offer keeps its grant so the slice sees stable data.
    assign grant     = lock_q ? lock_idx_q : arb_idx;
    assign can_issue = ~fifo_full & ~flush_i & ~rst_i;
    assign slv_valid_o = req_valid_i[grant] & can_issue;
    assign accept    = slv_valid_o & slv_ready_i;

    always_comb begin
        req_ready_o        = '0;
        req_ready_o[grant] = slv_ready_i & can_issue;
    end

    assign slv_operands_o  = req_operands_i[grant];
    assign slv_is_boxed_o  = req_is_boxed_i[grant];
    assign slv_rnd_mode_o  = req_rnd_mode_i[grant];
    assign slv_op_o        = req_op_i[grant];
    assign slv_op_mod_o    = req_op_mod_i[grant];
    assign slv_vectorial_o = req_vectorial_i[grant];
    assign slv_flush_o     = flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (flush_i) begin
            lock_q <= 1'b0;
        end else if (accept) begin
            rr_q   <= (grant == IdWidth'(NumReq - 1)) ? '0 : grant + IdWidth'(1);
            lock_q <= 1'b0;
        end else if (slv_valid_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= grant;
        end
    end

    fpnew_id_fifo #(
        .Depth   (MaxInflight),
        .IdWidth (IdWidth)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (accept),
        .id_i    (grant),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Results with no tracked owner are swallowed: never forwarded, never acked.
    assign rsp_active      = ~fifo_empty & ~rst_i;
    assign slv_out_ready_o = rsp_ready_i[fifo_head] & rsp_active;
    assign pop             = slv_out_valid_i & slv_out_ready_o;

    always_comb begin
        rsp_valid_o            = '0;
        rsp_valid_o[fifo_head] = slv_out_valid_i & rsp_active;
    end

    assign rsp_result_o = slv_result_i;
    assign rsp_status_o = slv_status_i;
    assign busy_o       = (~fifo_empty | slv_valid_o) & ~rst_i;

`ifndef SYNTHESIS
    a_no_orphan_result: assert property (@(posedge clk_i) disable iff (rst_i)
        !(slv_out_valid_i && fifo_empty));
`endif

endmodule

// File: tb/tb_fpnew_opgroup_arbiter.sv
// Directed bench for the opgroup arbiter: the bench plays both requesters and the slice.
module tb_fpnew_opgroup_arbiter;
    import fpnew_opgroup_arbiter_pkg::*;

    localparam int unsigned NumReq      = 2;
    localparam int unsigned Width       = 32;
    localparam int unsigned NumOperands = 3;
    localparam int unsigned MaxInflight = 3;

    logic clk_i = 1'b0;
    logic rst_i, flush_i;
    logic [NumReq-1:0]                             req_valid_i, req_ready_o;
    logic [NumReq-1:0][NumOperands-1:0][Width-1:0] req_operands_i;
    logic [NumReq-1:0][NumOperands-1:0]            req_is_boxed_i;
    roundmode_e [NumReq-1:0]                       req_rnd_mode_i;
    operation_e [NumReq-1:0]                       req_op_i;
    logic [NumReq-1:0]                             req_op_mod_i, req_vectorial_i;
    logic                                          slv_valid_o, slv_ready_i;
    logic [NumOperands-1:0][Width-1:0]             slv_operands_o;
    logic [NumOperands-1:0]                        slv_is_boxed_o;
    roundmode_e                                    slv_rnd_mode_o;
    operation_e                                    slv_op_o;
    logic                                          slv_op_mod_o, slv_vectorial_o, slv_flush_o;
    logic                                          slv_out_valid_i, slv_out_ready_o;
    logic [Width-1:0]                              slv_result_i, rsp_result_o;
    status_t                                       slv_status_i, rsp_status_o;
    logic [NumReq-1:0]                             rsp_valid_o, rsp_ready_i;
    logic                                          busy_o;

    int n_checks = 0;
    int n_errors = 0;

    fpnew_opgroup_arbiter #(
        .NumReq(NumReq), .Width(Width), .NumOperands(NumOperands), .MaxInflight(MaxInflight)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_operands_i(req_operands_i), .req_is_boxed_i(req_is_boxed_i),
        .req_rnd_mode_i(req_rnd_mode_i), .req_op_i(req_op_i),
        .req_op_mod_i(req_op_mod_i), .req_vectorial_i(req_vectorial_i),
        .slv_valid_o(slv_valid_o), .slv_ready_i(slv_ready_i),
        .slv_operands_o(slv_operands_o), .slv_is_boxed_o(slv_is_boxed_o),
        .slv_rnd_mode_o(slv_rnd_mode_o), .slv_op_o(slv_op_o),
        .slv_op_mod_o(slv_op_mod_o), .slv_vectorial_o(slv_vectorial_o),
        .slv_flush_o(slv_flush_o),
        .slv_out_valid_i(slv_out_valid_i), .slv_out_ready_o(slv_out_ready_o),
        .slv_result_i(slv_result_i), .slv_status_i(slv_status_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [NumOperands-1:0][Width-1:0] mk_ops(input int unsigned r,
                                                                 input int unsigned tag);
        logic [NumOperands-1:0][Width-1:0] o;
        for (int unsigned k = 0; k < NumOperands; k++) o[k] = 32'(tag * 4096 + r * 256 + k);
        return o;
    endfunction

    // Expected grant g: ready one-hot, data from requester g, op field from requester g.
    task automatic check_grant(input string tag, input int unsigned g, input logic [1:0] exp_rdy);
        check({tag, "_rdy"}, 128'(req_ready_o), 128'(exp_rdy));
        check({tag, "_vld"}, 128'(slv_valid_o), 128'(1'b1));
        check({tag, "_ops"}, 128'(slv_operands_o), 128'(req_operands_i[g]));
        check({tag, "_op"}, 128'(slv_op_o), 128'((g == 1) ? MUL : ADD));
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] exp_vld, input logic exp_ordy);
        check({tag, "_rvld"}, 128'(rsp_valid_o), 128'(exp_vld));
        check({tag, "_ordy"}, 128'(slv_out_ready_o), 128'(exp_ordy));
        check({tag, "_data"}, 128'(rsp_result_o), 128'(slv_result_i));
    endtask

    initial begin
        // Reset with traffic present on every input.
        rst_i = 1'b1; flush_i = 1'b0;
        req_valid_i = 2'b11; slv_ready_i = 1'b1;
        slv_out_valid_i = 1'b1; rsp_ready_i = 2'b11;
        req_operands_i[0] = mk_ops(0, 1);
        req_operands_i[1] = mk_ops(1, 1);
        req_is_boxed_i[0] = 3'b111; req_is_boxed_i[1] = 3'b010;
        req_rnd_mode_i[0] = RTZ;    req_rnd_mode_i[1] = RUP;
        req_op_i[0] = ADD;          req_op_i[1] = MUL;
        req_op_mod_i = 2'b10; req_vectorial_i = 2'b01;
        slv_result_i = 32'h0; slv_status_i = status_t'(5'b00000);
        #2;
        check("rst_rsp_valid", 128'(rsp_valid_o), 128'(2'b00));
        check("rst_busy", 128'(busy_o), 128'(1'b0));
        check("rst_slv_valid", 128'(slv_valid_o), 128'(1'b0));
        check("rst_req_ready", 128'(req_ready_o), 128'(2'b00));
        check("rst_out_ready", 128'(slv_out_ready_o), 128'(1'b0));
        step(); step();
        req_valid_i = 2'b00; slv_out_valid_i = 1'b0; rsp_ready_i = 2'b00;
        rst_i = 1'b0;
        #1;
        check("idle_busy", 128'(busy_o), 128'(1'b0));

        // First grant right after reset: requester 0 alone, all side fields muxed.
        req_valid_i = 2'b01;
        #1;
        check_grant("first", 0, 2'b01);
        check("first_rnd", 128'(slv_rnd_mode_o), 128'(RTZ));
        check("first_opmod", 128'(slv_op_mod_o), 128'(1'b0));
        check("first_vect", 128'(slv_vectorial_o), 128'(1'b1));
        check("first_boxed", 128'(slv_is_boxed_o), 128'(3'b111));
        step();
        req_valid_i = 2'b00;
        slv_out_valid_i = 1'b1; rsp_ready_i = 2'b11;
        slv_result_i = 32'hDEAD_0000; slv_status_i = status_t'(5'b10001);
        #1;
        check_rsp("rsp0", 2'b01, 1'b1);
        check("rsp0_status", 128'(rsp_status_o), 128'(5'b10001));
        check("rsp0_busy", 128'(busy_o), 128'(1'b1));
        step();
        slv_out_valid_i = 1'b0; rsp_ready_i = 2'b00;
        #1;
        check("post_rsp0_busy", 128'(busy_o), 128'(1'b0));

        // Both requesters continuously valid: pointer now at 1, so grants 1,0,1 fill the FIFO.
        req_valid_i = 2'b11; slv_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_grant($sformatf("rr%0d", i), (i % 2 == 0) ? 1 : 0,
                        (i % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("rr%0d_opmod", i), 128'(slv_op_mod_o),
                  128'((i % 2 == 0) ? 1'b1 : 1'b0));
            step();
        end
        #1;
        check("full_req_ready", 128'(req_ready_o), 128'(2'b00));
        check("full_slv_valid", 128'(slv_valid_o), 128'(1'b0));
        check("full_busy", 128'(busy_o), 128'(1'b1));

        // Pop while full with requests pending: no push this cycle.
        slv_out_valid_i = 1'b1; rsp_ready_i = 2'b11; slv_result_i = 32'h1111_0001;
        #1;
        check_rsp("fullpop", 2'b10, 1'b1);
        check("fullpop_req_ready", 128'(req_ready_o), 128'(2'b00));
        step();

        // One slot free: push (grant 0) and pop (head 0) together.
        slv_result_i = 32'h2222_0000;
        #1;
        check("pushpop_req_ready", 128'(req_ready_o), 128'(2'b01));
        check_rsp("pushpop", 2'b01, 1'b1);
        step();

        // Head is requester 1: requester 0's ready must not pop it.
        req_valid_i = 2'b00; slv_result_i = 32'h3333_0001; rsp_ready_i = 2'b01;
        #1;
        check_rsp("bp_wrong", 2'b10, 1'b0);
        step();
        check("bp_hold", 128'(rsp_valid_o), 128'(2'b10));
        rsp_ready_i = 2'b10;
        #1;
        check_rsp("bp_right", 2'b10, 1'b1);
        step();
        slv_result_i = 32'h4444_0000; rsp_ready_i = 2'b11;
        #1;
        check_rsp("wrap_head", 2'b01, 1'b1);
        step();
        slv_out_valid_i = 1'b0; rsp_ready_i = 2'b00;
        #1;
        check("drained_busy", 128'(busy_o), 128'(1'b0));
        check("drained_rvld", 128'(rsp_valid_o), 128'(2'b00));

        // Move the pointer to 0, then stall a grant to requester 1.
        req_valid_i = 2'b10;
        #1;
        check_grant("pre_lock", 1, 2'b10);
        step();
        slv_ready_i = 1'b0; req_operands_i[1] = mk_ops(1, 2);
        #1;
        check_grant("lock0", 1, 2'b00);
        step();
        req_valid_i = 2'b11; req_operands_i[0] = mk_ops(0, 3);
        for (int i = 1; i < 3; i++) begin
            #1;
            check_grant($sformatf("lock%0d", i), 1, 2'b00);
            step();
        end
        slv_ready_i = 1'b1;
        #1;
        check_grant("lock_acc", 1, 2'b10);
        step();
        req_valid_i = 2'b01;
        #1;
        check_grant("after_lock", 0, 2'b01);
        step();

        // Three in flight, flush pulse.
        flush_i = 1'b1;
        #1;
        check("flush_fwd", 128'(slv_flush_o), 128'(1'b1));
        check("flush_slv_valid", 128'(slv_valid_o), 128'(1'b0));
        check("flush_busy", 128'(busy_o), 128'(1'b1));
        step();
        flush_i = 1'b0; req_valid_i = 2'b00;
        #1;
        check("postflush_busy", 128'(busy_o), 128'(1'b0));
        check("postflush_fwd", 128'(slv_flush_o), 128'(1'b0));
        // Pointer kept at 1 across flush, so requester 1 wins.
        req_valid_i = 2'b11;
        #1;
        check_grant("postflush", 1, 2'b10);
        step();
        req_valid_i = 2'b00;
        slv_out_valid_i = 1'b1; rsp_ready_i = 2'b11; slv_result_i = 32'h5555_0001;
        #1;
        check_rsp("postflush_rsp", 2'b10, 1'b1);
        step();
        slv_out_valid_i = 1'b0; rsp_ready_i = 2'b00;
        #1;
        check("final_busy", 128'(busy_o), 128'(1'b0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
